// File: rtl/ex_muldiv_unit.sv
// Iterative RV32M multiply/divide unit for the EX stage. It stalls the pipeline while it iterates,
// then pulses done with result/rd_out for EX/MEM capture.
module ex_muldiv_unit #(
    parameter int XLEN     = 32,
    parameter int MUL_STEP = 1,
    parameter int FAST_DIV = 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            flush,
    input  logic            start,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic [4:0]      rd_in,
    output logic            stall_req,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result,
    output logic [4:0]      rd_out
);

    localparam int            CW        = $clog2(XLEN + 1);
    localparam logic [CW-1:0] MUL_COUNT = CW'(XLEN / MUL_STEP);
    localparam logic [CW-1:0] DIV_COUNT = CW'(XLEN);
    localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, MUL_RUN, DIV_RUN, DONE} state_t;

    state_t            state, state_next;
    logic [2:0]        op_q;
    logic              sa_q, sb_q, bnz_q;
    logic [CW-1:0]     count;
    logic [2*XLEN-1:0] acc, mcand;
    logic [XLEN-1:0]   mplr, quo, rem_r, divisor;

    logic              is_div, a_signed, b_signed, sa, sb;
    logic              div_zero, overflow, fast, issue;
    logic [XLEN-1:0]   a_mag, b_mag, fast_result;

    logic [2*XLEN-1:0] mul_sum, mul_prod, step_mcand;
    logic [XLEN-1:0]   step_bits;
    logic [XLEN:0]     div_shift, div_diff;
    logic [XLEN-1:0]   quo_next, rem_next, quo_final, rem_final, final_result;

    // Issue-time decode: signedness, magnitudes and the cases that need no iteration
    always_comb begin
        is_div      = op[2];
        a_signed    = (op == 3'd1) || (op == 3'd2) || (op == 3'd4) || (op == 3'd6);
        b_signed    = (op == 3'd1) || (op == 3'd4) || (op == 3'd6);
        sa          = a_signed && a[XLEN-1];
        sb          = b_signed && b[XLEN-1];
        a_mag       = sa ? -a : a;
        b_mag       = sb ? -b : b;
        div_zero    = (b == '0);
        overflow    = ((op == 3'd4) || (op == 3'd6)) && (a == MIN_INT) && (b == '1);
        fast        = (FAST_DIV != 0) && is_div && (div_zero || overflow);
        fast_result = '0;
        if (div_zero)
            fast_result = op[1] ? a : '1;
        else if (overflow)
            fast_result = op[1] ? '0 : MIN_INT;
        issue       = (state == IDLE) && start && !flush;
    end

    // One iteration step of each datapath plus the sign-corrected final values
    always_comb begin
        mul_sum    = acc;
        step_bits  = mplr;
        step_mcand = mcand;
        for (int i = 0; i < MUL_STEP; i++) begin
            if (step_bits[0])
                mul_sum = mul_sum + step_mcand;
            step_bits  = step_bits >> 1;
            step_mcand = step_mcand << 1;
        end
        mul_prod  = (sa_q ^ sb_q) ? -mul_sum : mul_sum;

        div_shift = {rem_r, quo[XLEN-1]};
        div_diff  = div_shift - {1'b0, divisor};
        if (!div_diff[XLEN]) begin
            rem_next = div_diff[XLEN-1:0];
            quo_next = {quo[XLEN-2:0], 1'b1};
        end else begin
            rem_next = div_shift[XLEN-1:0];
            quo_next = {quo[XLEN-2:0], 1'b0};
        end
        // A zero divisor keeps the all-ones quotient regardless of the dividend sign
        quo_final = ((sa_q ^ sb_q) && bnz_q) ? -quo_next : quo_next;
        rem_final = sa_q ? -rem_next : rem_next;

        case (op_q)
            3'd0:             final_result = mul_prod[XLEN-1:0];
            3'd1, 3'd2, 3'd3: final_result = mul_prod[2*XLEN-1:XLEN];
            3'd4, 3'd5:       final_result = quo_final;
            default:          final_result = rem_final;
        endcase
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:             if (issue) state_next = fast ? DONE : (is_div ? DIV_RUN : MUL_RUN);
            MUL_RUN, DIV_RUN: if (count == CW'(1)) state_next = DONE;
            DONE:             state_next = IDLE;
            default:          state_next = IDLE;
        endcase
        if (flush)
            state_next = IDLE;
    end

    assign busy      = (state == MUL_RUN) || (state == DIV_RUN);
    assign done      = (state == DONE);
    assign stall_req = issue || busy;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            op_q    <= '0;
            sa_q    <= 1'b0;
            sb_q    <= 1'b0;
            bnz_q   <= 1'b0;
            count   <= '0;
            acc     <= '0;
            mcand   <= '0;
            mplr    <= '0;
            quo     <= '0;
            rem_r   <= '0;
            divisor <= '0;
            result  <= '0;
            rd_out  <= '0;
        end else begin
            state <= state_next;
            if (issue) begin
                op_q    <= op;
                rd_out  <= rd_in;
                sa_q    <= sa;
                sb_q    <= sb;
                bnz_q   <= !div_zero;
                count   <= is_div ? DIV_COUNT : MUL_COUNT;
                acc     <= '0;
                mcand   <= {{XLEN{1'b0}}, a_mag};
                mplr    <= b_mag;
                quo     <= a_mag;
                rem_r   <= '0;
                divisor <= b_mag;
                if (fast)
                    result <= fast_result;
            end else if (busy && !flush) begin
                count <= count - CW'(1);
                if (state == MUL_RUN) begin
                    acc   <= mul_sum;
                    mcand <= mcand << MUL_STEP;
                    mplr  <= mplr >> MUL_STEP;
                end else begin
                    quo   <= quo_next;
                    rem_r <= rem_next;
                end
                if (count == CW'(1))
                    result <= final_result;
            end
        end
    end

endmodule
